// File: rtl/counter_up_down_param.sv
// Up/down counter with inclusive runtime bounds, wrap or saturate at the bounds,
// a registered terminal-count pulse and sticky overflow/underflow flags.
module counter_up_down_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             sclr,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             mode,
    input  logic             sat,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lim_lo,
    input  logic [WIDTH-1:0] lim_hi,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             udf,
    output logic             cfg_err
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic             in_rng;
    logic             step_ok;
    logic             up_ev;
    logic             dn_ev;
    logic [WIDTH-1:0] cnt_nxt;

    assign cfg_err = lim_lo > lim_hi;

    always_comb begin
        sum     = {1'b0, count} + {1'b0, step};
        dif     = {1'b0, count} - {1'b0, step};
        in_rng  = (count >= lim_lo) && (count <= lim_hi);
        step_ok = en && !sclr && !ld && !cfg_err && (step != '0);
        // A count stranded outside the bounds by a limit change always takes
        // the boundary action for the requested direction.
        up_ev   = step_ok && !mode && (!in_rng || (sum > {1'b0, lim_hi}));
        dn_ev   = step_ok && mode &&
                  (!in_rng || dif[WIDTH] || (dif[WIDTH-1:0] < lim_lo));

        cnt_nxt = count;
        if (sclr)
            cnt_nxt = lim_lo;
        else if (cfg_err)
            cnt_nxt = count;
        else if (ld)
            cnt_nxt = (din < lim_lo) ? lim_lo : ((din > lim_hi) ? lim_hi : din);
        else if (up_ev)
            cnt_nxt = sat ? lim_hi : lim_lo;
        else if (dn_ev)
            cnt_nxt = sat ? lim_lo : lim_hi;
        else if (step_ok)
            cnt_nxt = mode ? dif[WIDTH-1:0] : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            count <= cnt_nxt;
            tc    <= up_ev || dn_ev;
            // A new event beats a coincident flag clear.
            ovf   <= up_ev || (ovf && !flag_clr);
            udf   <= dn_ev || (udf && !flag_clr);
        end
    end

endmodule

// File: tb/tb_counter_up_down_param.sv
// Bench for counter_up_down_param: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an arithmetic model.
module tb_counter_up_down_param;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr_n, sclr, ld, en, mode, sat, flag_clr;
    logic [W-1:0] din, step, lim_lo, lim_hi;
    logic [W-1:0] count;
    logic         tc, ovf, udf, cfg_err;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // model state
    int m_cnt, m_tc, m_ovf, m_udf;
    int lo, hi, c, s;
    longint n;
    bit ev_o, ev_u;

    counter_up_down_param #(.WIDTH(W)) dut (
        .clk(clk), .clr_n(clr_n), .sclr(sclr), .ld(ld), .din(din), .en(en),
        .mode(mode), .sat(sat), .step(step), .lim_lo(lim_lo), .lim_hi(lim_hi),
        .flag_clr(flag_clr), .count(count), .tc(tc), .ovf(ovf), .udf(udf),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_cnt = 0; m_tc = 0; m_ovf = 0; m_udf = 0;
        end else begin
            lo = int'(lim_lo); hi = int'(lim_hi); c = m_cnt; s = int'(step);
            ev_o = 1'b0; ev_u = 1'b0;
            if (sclr) c = lo;
            else if (lo > hi) c = m_cnt;
            else if (ld) c = (int'(din) < lo) ? lo : ((int'(din) > hi) ? hi : int'(din));
            else if (en && s != 0) begin
                n = mode ? longint'(c) - s : longint'(c) + s;
                if (!mode && (c < lo || c > hi || n > hi)) begin
                    ev_o = 1'b1; c = sat ? hi : lo;
                end else if (mode && (c < lo || c > hi || n < lo)) begin
                    ev_u = 1'b1; c = sat ? lo : hi;
                end else c = int'(n);
            end
            m_cnt = c;
            m_tc  = int'(ev_o | ev_u);
            m_ovf = int'(ev_o || (m_ovf != 0 && !flag_clr));
            m_udf = int'(ev_u || (m_udf != 0 && !flag_clr));
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("count", int'(count), m_cnt);
            chk("tc", int'(tc), m_tc);
            chk("ovf", int'(ovf), m_ovf);
            chk("udf", int'(udf), m_udf);
            chk("cfg_err", int'(cfg_err), int'(lim_lo > lim_hi));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        sclr = 0; ld = 0; en = 0; flag_clr = 0;
    endtask

    int exp_seq[8] = '{251, 252, 253, 254, 255, 0, 1, 2};
    int exp_dn[4]  = '{12, 10, 10, 10};

    initial begin
        clr_n = 0; idle(); din = 0; mode = 0; sat = 0; step = 1;
        lim_lo = 0; lim_hi = 255;
        #12;
        chk("reset_count", int'(count), 0);
        chk("reset_tc", int'(tc), 0);
        chk("reset_flags", int'({ovf, udf}), 0);
        @(negedge clk); clr_n = 1;
        cyc();
        chk_on = 1'b1;

        // up wrap across 255
        ld = 1; din = 250; cyc(); ld = 0; en = 1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("up_wrap_count", int'(count), exp_seq[i]);
            chk("up_wrap_tc", int'(tc), int'(i == 5));
        end
        chk("up_wrap_ovf", int'(ovf), 1);
        en = 0; flag_clr = 1; cyc(); flag_clr = 0;
        chk("flag_clr", int'(ovf), 0);

        // down saturate below 10
        lim_lo = 10; lim_hi = 20; step = 3; mode = 1; sat = 1;
        ld = 1; din = 15; cyc(); ld = 0; en = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("dn_sat_count", int'(count), exp_dn[i]);
            chk("dn_sat_tc", int'(tc), int'(i >= 1));
        end
        chk("dn_sat_udf", int'(udf), 1);
        en = 0; flag_clr = 1; cyc(); flag_clr = 0;

        // load clamping
        ld = 1; din = 5; cyc();
        chk("ld_clamp_lo", int'(count), 10);
        din = 200; cyc();
        chk("ld_clamp_hi", int'(count), 20);
        chk("ld_no_tc", int'({tc, ovf, udf}), 0);

        // priority
        lim_lo = 4; sclr = 1; ld = 1; din = 17; cyc();
        chk("sclr_over_ld", int'(count), 4);
        sclr = 0; en = 1; mode = 0; step = 1; din = 13; cyc();
        chk("ld_over_en", int'(count), 13);
        ld = 0; step = 0; cyc();
        chk("step0_hold", int'(count), 13);
        chk("step0_no_tc", int'(tc), 0);
        step = 7; cyc();
        chk("land_on_hi", int'(count), 20);
        chk("land_on_hi_tc", int'({tc, ovf}), 0);

        // bad configuration
        en = 0; lim_lo = 30; lim_hi = 20; #1;
        chk("cfg_err", int'(cfg_err), 1);
        en = 1; ld = 1; din = 25;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("cfg_hold", int'(count), 20);
            chk("cfg_no_tc", int'(tc), 0);
        end
        en = 0; ld = 0; sclr = 1; cyc(); sclr = 0;
        chk("cfg_sclr", int'(count), 30);

        // limits moved under the count: up step takes overflow action
        lim_lo = 40; lim_hi = 50; sat = 0; mode = 0; step = 1; en = 1; cyc();
        chk("oor_up_count", int'(count), 40);
        chk("oor_up_ovf", int'(ovf), 1);

        // async reset mid-count
        lim_lo = 0; lim_hi = 255; ld = 1; din = 8'h80; en = 0; cyc();
        ld = 0; en = 1; cyc(); cyc();
        chk_on = 1'b0;
        #1 clr_n = 0; #1;
        chk("async_count", int'(count), 0);
        chk("async_flags", int'({tc, ovf, udf}), 0);
        @(negedge clk); clr_n = 1; idle();
        cyc(); chk_on = 1'b1;

        // set beats flag_clr
        ld = 1; din = 255; cyc(); ld = 0; en = 1; cyc();
        chk("ovf_set", int'(ovf), 1);
        ld = 1; cyc(); ld = 0; flag_clr = 1; cyc();
        chk("set_beats_clr", int'(ovf), 1);
        chk("set_beats_clr_tc", int'(tc), 1);
        idle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ((i % 16) == 0) begin
                lim_lo = W'($urandom_range(0, 120));
                lim_hi = W'($urandom_range(0, 255));
                if ($urandom_range(0, 9) != 0 && lim_lo > lim_hi) lim_hi = 8'd255;
            end
            sclr     = ($urandom_range(0, 49) == 0);
            ld       = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 9) < 7);
            flag_clr = ($urandom_range(0, 19) == 0);
            mode     = W'($urandom_range(0, 1)) != 0;
            sat      = W'($urandom_range(0, 1)) != 0;
            step     = ($urandom_range(0, 19) == 0) ? 8'd0 : W'($urandom_range(1, 60));
            din      = W'($urandom_range(0, 255));
            cyc();
        end
        idle();
        cyc();
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_up_down_param.md
COUNTER_UP_DOWN_PARAM -- requirements
Module: counter_up_down_param

Interface
REQ-001 The block SHALL have one parameter, WIDTH, with default 8, giving the count and data width in bits (legal range 2..32).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 clr_n  input  1  asynchronous, active-low reset.
REQ-004 sclr  input  1  synchronous clear of the count to lim_lo.
REQ-005 ld  input  1  synchronous load of din.
REQ-006 din  input  WIDTH  load value.
REQ-007 en  input  1  count enable.
REQ-008 mode  input  1  count direction: 0 = up, 1 = down.
REQ-009 sat  input  1  boundary behaviour: 0 = wrap, 1 = saturate.
REQ-010 step  input  WIDTH  increment or decrement amount per enabled cycle.
REQ-011 lim_lo, lim_hi  input  WIDTH each  inclusive lower and upper count bounds, both unsigned.
REQ-012 flag_clr  input  1  synchronous clear of the sticky flags.
REQ-013 count  output  WIDTH  registered count.
REQ-014 tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 ovf, udf  output  1 each  sticky overflow and underflow flags.
REQ-016 cfg_err  output  1  combinational; high while lim_lo > lim_hi.

Function
REQ-017 Priority per cycle SHALL be sclr > ld > en; if none is active, count holds.
REQ-018 sclr SHALL set count to lim_lo.
REQ-019 ld SHALL set count to din clamped into [lim_lo, lim_hi], i.e. below lim_lo gives lim_lo and above lim_hi gives lim_hi.
REQ-020 Neither sclr nor ld SHALL assert tc, ovf or udf.
REQ-021 Up counting SHALL compute nxt = count + step in WIDTH+1 bits and compare it unsigned against lim_hi, so the sum never silently truncates.
REQ-022 Down counting SHALL compute nxt = count - step and treat a borrow, or nxt < lim_lo, as an underflow.
REQ-023 In range (lim_lo <= nxt <= lim_hi), count SHALL become nxt and tc SHALL stay 0.
REQ-024 Up past lim_hi SHALL give, in wrap mode, count = lim_lo (overshoot discarded); in saturate mode, count = lim_hi. Either way, tc = 1 on the next cycle and ovf is set.
REQ-025 Down past lim_lo SHALL give, in wrap mode, count = lim_hi; in saturate mode, count = lim_lo. Either way, tc = 1 on the next cycle and udf is set.
REQ-026 In saturate mode, a repeated enabled step while already at the bound SHALL re-pulse tc every such cycle.
REQ-027 A nxt landing exactly on lim_hi or lim_lo SHALL be in range: no tc, no flag.
REQ-028 step = 0 with en = 1 SHALL hold count with no tc and no flags.
REQ-029 While cfg_err = 1, counting and loading SHALL be suppressed: count holds and tc = 0. sclr still applies.
REQ-030 A count that lies outside [lim_lo, lim_hi] because the limits changed at runtime SHALL be treated as out of range on the next enabled step: a step in either direction SHALL apply the REQ-024/025 boundary action for that direction.
REQ-031 ovf and udf SHALL remain set until flag_clr or reset.
REQ-032 When flag_clr coincides with a new overflow or underflow event, set SHALL win.
REQ-033 mode, sat, step and the limits MAY change on any cycle and SHALL take effect on that same edge.

Reset
REQ-034 clr_n = 0 SHALL immediately, without waiting for a clock edge, force count = 0, tc = 0, ovf = 0 and udf = 0.
REQ-035 Deassertion of clr_n is synchronised externally; the first active edge after deassertion SHALL follow REQ-017.
REQ-036 Reset mid-count SHALL discard the in-flight step; no tc is produced for it.

Verification
REQ-037 WIDTH=8, lo=0, hi=255, step=1, up, wrap; load 250, en for 8 cycles -> count 251..255, then 0, 1, 2; tc high for exactly the one cycle after 255->0; ovf=1.
REQ-038 lo=10, hi=20, step=3, down, sat; load 15, en for 4 cycles -> 12, 10, 10, 10; tc pulses on cycles 2..4 (each after an attempted step below lim_lo); udf=1.
REQ-039 lo=10, hi=20; ld din=5 -> count 10; ld din=200 -> count 20; no tc, no flags.
REQ-040 ld=1 with sclr=1 at lo=4 -> count 4; ld=1 with en=1 -> count = loaded value, no step applied.
REQ-041 lo=30, hi=20 -> cfg_err=1; en and ld held for 3 cycles -> count unchanged; sclr -> count 30.
REQ-042 Counting up at count 0x80, pull clr_n low between clock edges -> count=0 and flags cleared before the next edge; flag_clr in the same cycle as a new overflow -> ovf stays 1.
